reg_host_bridge: RTL and testbench



---
 rtl/reg_host_bridge_if.sv | 34 +++
 rtl/reg_host_bridge.sv | 170 +++++++++++++++++
 tb/tb_reg_host_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_host_bridge_if.sv
// Bundles the host request port, the RMON request port and the CPU strobe bus
// of the MAC register block.
//   master : bridge side (receives host/RMON requests, drives CSB/WRB/CA/CD_wr)
//   slave  : environment side (host, RMON client and register block)
interface reg_host_bridge_if;
    logic        Host_req;
    logic        Host_we;
    logic [7:0]  Host_addr;
    logic [15:0] Host_wdata;
    logic        Host_ack;
    logic [15:0] Host_rdata;

    logic        Rmon_req;
    logic [5:0]  Rmon_addr;
    logic        Rmon_ack;
    logic [31:0] Rmon_data;
    logic        Rmon_err;

    logic        CSB;
    logic        WRB;
    logic [7:0]  CA;
    logic [15:0] CD_wr;
    logic [15:0] CD_rd;

    modport master (
        input  Host_req, Host_we, Host_addr, Host_wdata, Rmon_req, Rmon_addr, CD_rd,
        output Host_ack, Host_rdata, Rmon_ack, Rmon_data, Rmon_err, CSB, WRB, CA, CD_wr
    );

    modport slave (
        output Host_req, Host_we, Host_addr, Host_wdata, Rmon_req, Rmon_addr, CD_rd,
        input  Host_ack, Host_rdata, Rmon_ack, Rmon_data, Rmon_err, CSB, WRB, CA, CD_wr
    );
endinterface

// File: rtl/reg_host_bridge.sv
// Sole master of the MAC register block. Turns single host reads/writes into
// one-cycle CSB strobes and runs the RMON counter read handshake
// (select, apply, poll grant, read low/high halves, clear apply).
// Ports:
//   Clk_reg : register-domain clock, rising edge
//   Reset   : synchronous active-high reset
//   bus     : host + RMON request ports and CPU strobe bus (master modport)
module reg_host_bridge #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic               Clk_reg,
    input  logic               Reset,
    reg_host_bridge_if.master  bus
);

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);
    localparam logic [7:0] ADDR_SEL   = 8'h38;
    localparam logic [7:0] ADDR_APPLY = 8'h3A;
    localparam logic [7:0] ADDR_GRANT = 8'h3C;
    localparam logic [7:0] ADDR_LO    = 8'h3E;
    localparam logic [7:0] ADDR_HI    = 8'h40;

    typedef enum logic [3:0] {
        IDLE, HWR, HRD, HCAP,
        RADDR, RAPPLY, RPOLL, RPCAP,
        RLO, RLCAP, RHI, RHCAP, RCLR, ACK
    } state_t;

    state_t      state, state_n;
    logic        serve_rmon, serve_rmon_n;
    logic [7:0]  poll_cnt;
    logic [7:0]  poll_inc;
    logic        err_flag;
    logic        timeout_c;
    logic        csb_n, wrb_n;
    logic [7:0]  ca_n;
    logic [15:0] cdw_n;

    assign poll_inc  = poll_cnt + 8'd1;
    assign timeout_c = (state == RPCAP) && !bus.CD_rd[0] && (poll_inc == POLL_LIMIT);

    // State register
    always_ff @(posedge Clk_reg) begin
        if (Reset) begin
            state      <= IDLE;
            serve_rmon <= 1'b0;
        end else begin
            state      <= state_n;
            serve_rmon <= serve_rmon_n;
        end
    end

    // Next state, then strobe values decoded from the state being entered so
    // that the registered bus outputs line up with that state's cycle.
    always_comb begin
        state_n      = state;
        serve_rmon_n = serve_rmon;
        csb_n        = 1'b1;
        wrb_n        = 1'b1;
        ca_n         = bus.CA;
        cdw_n        = bus.CD_wr;

        case (state)
            IDLE: begin
                if (bus.Host_req) begin
                    serve_rmon_n = 1'b0;
                    state_n      = bus.Host_we ? HWR : HRD;
                end else if (bus.Rmon_req) begin
                    serve_rmon_n = 1'b1;
                    state_n      = RADDR;
                end
            end
            HWR:    state_n = ACK;
            HRD:    state_n = HCAP;
            HCAP:   state_n = ACK;
            RADDR:  state_n = RAPPLY;
            RAPPLY: state_n = RPOLL;
            RPOLL:  state_n = RPCAP;
            RPCAP: begin
                if (bus.CD_rd[0])
                    state_n = RLO;
                else if (poll_inc == POLL_LIMIT)
                    state_n = RCLR;
                else
                    state_n = RPOLL;
            end
            RLO:    state_n = RLCAP;
            RLCAP:  state_n = RHI;
            RHI:    state_n = RHCAP;
            RHCAP:  state_n = RCLR;
            RCLR:   state_n = ACK;
            ACK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        case (state_n)
            HWR: begin
                csb_n = 1'b0; wrb_n = 1'b0;
                ca_n  = bus.Host_addr; cdw_n = bus.Host_wdata;
            end
            HRD: begin
                csb_n = 1'b0; ca_n = bus.Host_addr;
            end
            RADDR: begin
                csb_n = 1'b0; wrb_n = 1'b0;
                ca_n  = ADDR_SEL; cdw_n = {10'b0, bus.Rmon_addr};
            end
            RAPPLY: begin
                csb_n = 1'b0; wrb_n = 1'b0;
                ca_n  = ADDR_APPLY; cdw_n = 16'h0001;
            end
            RPOLL: begin
                csb_n = 1'b0; ca_n = ADDR_GRANT;
            end
            RLO: begin
                csb_n = 1'b0; ca_n = ADDR_LO;
            end
            RHI: begin
                csb_n = 1'b0; ca_n = ADDR_HI;
            end
            RCLR: begin
                csb_n = 1'b0; wrb_n = 1'b0;
                ca_n  = ADDR_APPLY; cdw_n = 16'h0000;
            end
            default: ;
        endcase
    end

    // Registered outputs, poll counter and data capture
    always_ff @(posedge Clk_reg) begin
        if (Reset) begin
            bus.CSB        <= 1'b1;
            bus.WRB        <= 1'b1;
            bus.CA         <= 8'h00;
            bus.CD_wr      <= 16'h0000;
            bus.Host_ack   <= 1'b0;
            bus.Host_rdata <= 16'h0000;
            bus.Rmon_ack   <= 1'b0;
            bus.Rmon_data  <= 32'h0;
            bus.Rmon_err   <= 1'b0;
            poll_cnt       <= 8'd0;
            err_flag       <= 1'b0;
        end else begin
            bus.CSB      <= csb_n;
            bus.WRB      <= wrb_n;
            bus.CA       <= ca_n;
            bus.CD_wr    <= cdw_n;
            bus.Host_ack <= (state_n == ACK) && !serve_rmon;
            bus.Rmon_ack <= (state_n == ACK) && serve_rmon;
            bus.Rmon_err <= (state_n == ACK) && serve_rmon && err_flag;

            if (state == RAPPLY) begin
                poll_cnt <= 8'd0;
                err_flag <= 1'b0;
            end else if (state == RPCAP && !bus.CD_rd[0]) begin
                poll_cnt <= poll_inc;
            end

            if (timeout_c) begin
                err_flag      <= 1'b1;
                bus.Rmon_data <= 32'h0;
            end

            if (state == HCAP)  bus.Host_rdata       <= bus.CD_rd;
            if (state == RLCAP) bus.Rmon_data[15:0]  <= bus.CD_rd;
            if (state == RHCAP) bus.Rmon_data[31:16] <= bus.CD_rd;
        end
    end

endmodule

// File: tb/tb_reg_host_bridge.sv
// Directed bench for reg_host_bridge with a behavioural register block model
// (registered read data, RMON select/apply/grant/low/high registers).
module tb_reg_host_bridge;

    logic clk;
    logic Reset;
    reg_host_bridge_if bus ();

    reg_host_bridge #(.POLL_MAX(4)) dut (
        .Clk_reg (clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- register block model ----------------
    logic [15:0] mem [0:255];
    logic [15:0] cd_rd;
    logic        apply;
    int          poll_seen;
    int          grant_polls;    // grant on this poll after apply; 0 = never
    logic [31:0] rmon_val;
    logic        bd_en;
    logic [7:0]  bd_addr;
    logic [15:0] bd_data;

    assign bus.CD_rd = cd_rd;

    always @(posedge clk) begin
        if (Reset) begin
            cd_rd     <= 16'h0;
            apply     <= 1'b0;
            poll_seen <= 0;
        end else begin
            if (bd_en) mem[bd_addr] <= bd_data;
            if (!bus.CSB && !bus.WRB) begin
                mem[bus.CA] <= bus.CD_wr;
                if (bus.CA == 8'h3A) begin
                    apply     <= bus.CD_wr[0];
                    poll_seen <= 0;
                end
            end
            if (!bus.CSB && bus.WRB) begin
                case (bus.CA)
                    8'h3C: begin
                        poll_seen <= poll_seen + 1;
                        cd_rd <= {15'b0, (grant_polls != 0 && poll_seen + 1 >= grant_polls)};
                    end
                    8'h3E:   cd_rd <= rmon_val[15:0];
                    8'h40:   cd_rd <= rmon_val[31:16];
                    default: cd_rd <= mem[bus.CA];
                endcase
            end
        end
    end

    // ---------------- strobe / ack monitor ----------------
    logic [24:0] log_q[$];   // {WRB, CA, write data (0 for reads)}
    int          host_acks = 0;
    int          rmon_acks = 0;

    always @(negedge clk) begin
        if (!Reset) begin
            if (!bus.CSB) log_q.push_back({bus.WRB, bus.CA, bus.WRB ? 16'h0 : bus.CD_wr});
            if (bus.Host_ack) host_acks++;
            if (bus.Rmon_ack) rmon_acks++;
        end
    end

    function automatic int count_entry(input logic [24:0] e);
        int c = 0;
        foreach (log_q[i]) if (log_q[i] == e) c++;
        return c;
    endfunction

    // Raise the selected requests together, drop each on its ack, return
    // the ack cycle relative to cycle 0 (first cycle the request is high).
    task automatic run_req(input bit h, input bit r, output int h_lat, output int r_lat);
        bit h_done, r_done;
        h_lat = -1; r_lat = -1;
        h_done = !h; r_done = !r;
        @(posedge clk); #1;
        bus.Host_req = h;
        bus.Rmon_req = r;
        for (int n = 1; n <= 200 && !(h_done && r_done); n++) begin
            @(posedge clk); #1;
            if (bus.Host_ack) begin
                if (!h_done) h_lat = n;
                h_done = 1'b1;
                bus.Host_req = 1'b0;
            end
            if (bus.Rmon_ack) begin
                if (!r_done) r_lat = n;
                r_done = 1'b1;
                bus.Rmon_req = 1'b0;
            end
        end
        if (!(h_done && r_done)) begin
            check("txn_bound", 32'd0, 32'd1);
            bus.Host_req = 1'b0;
            bus.Rmon_req = 1'b0;
        end
    endtask

    int hl, rl, acks_before;
    bit seen_poll;

    initial begin
        Reset = 1'b1;
        bus.Host_req = 0; bus.Host_we = 0; bus.Host_addr = 0; bus.Host_wdata = 0;
        bus.Rmon_req = 0; bus.Rmon_addr = 0;
        grant_polls = 0; rmon_val = 0;
        bd_en = 0; bd_addr = 0; bd_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb",    32'(bus.CSB), 32'd1);
        check("rst_wrb",    32'(bus.WRB), 32'd1);
        check("rst_ca",     32'(bus.CA), 32'd0);
        check("rst_cdwr",   32'(bus.CD_wr), 32'd0);
        check("rst_hack",   32'(bus.Host_ack), 32'd0);
        check("rst_hrdata", 32'(bus.Host_rdata), 32'd0);
        check("rst_rack",   32'(bus.Rmon_ack), 32'd0);
        check("rst_rdata",  bus.Rmon_data, 32'd0);
        check("rst_rerr",   32'(bus.Rmon_err), 32'd0);
        Reset = 1'b0;

        // Host write 0x08 <- 0x0005
        log_q.delete();
        bus.Host_we = 1; bus.Host_addr = 8'h08; bus.Host_wdata = 16'h0005;
        run_req(1, 0, hl, rl);
        check("hwr_lat",   32'(hl), 32'd2);
        check("hwr_nstb",  32'(log_q.size()), 32'd1);
        check("hwr_strobe", 32'(log_q[0]), 32'({1'b0, 8'h08, 16'h0005}));
        // Read it back through the bridge
        bus.Host_we = 0;
        run_req(1, 0, hl, rl);
        check("hrb_lat",  32'(hl), 32'd3);
        check("hrb_data", 32'(bus.Host_rdata), 32'h0005);

        // Host read of 0x34, model holds 0x2710
        @(posedge clk); #1;
        bd_en = 1; bd_addr = 8'h34; bd_data = 16'h2710;
        @(posedge clk); #1;
        bd_en = 0;
        log_q.delete();
        bus.Host_we = 0; bus.Host_addr = 8'h34;
        run_req(1, 0, hl, rl);
        check("hrd_lat",    32'(hl), 32'd3);
        check("hrd_data",   32'(bus.Host_rdata), 32'h2710);
        check("hrd_nstb",   32'(log_q.size()), 32'd1);
        check("hrd_strobe", 32'(log_q[0]), 32'({1'b1, 8'h34, 16'h0}));
        repeat (3) @(posedge clk);
        #1;
        check("hrd_hold",   32'(bus.Host_rdata), 32'h2710);

        // RMON read, grant on third poll
        log_q.delete();
        bus.Rmon_addr = 6'h15; grant_polls = 3; rmon_val = 32'hDEADBEEF;
        run_req(0, 1, hl, rl);
        check("rmon_lat",   32'(rl), 32'd14);
        check("rmon_data",  bus.Rmon_data, 32'hDEADBEEF);
        check("rmon_err",   32'(bus.Rmon_err), 32'd0);
        check("rmon_nstb",  32'(log_q.size()), 32'd8);
        check("rmon_sel",   32'(log_q[0]), 32'({1'b0, 8'h38, 16'h0015}));
        check("rmon_apply", 32'(log_q[1]), 32'({1'b0, 8'h3A, 16'h0001}));
        check("rmon_polls", 32'(count_entry({1'b1, 8'h3C, 16'h0})), 32'd3);
        check("rmon_lo",    32'(log_q[5]), 32'({1'b1, 8'h3E, 16'h0}));
        check("rmon_hi",    32'(log_q[6]), 32'({1'b1, 8'h40, 16'h0}));
        check("rmon_clr",   32'(log_q[7]), 32'({1'b0, 8'h3A, 16'h0000}));
        check("rmon_applyoff", 32'(apply), 32'd0);

        // RMON timeout, POLL_MAX = 4
        log_q.delete();
        grant_polls = 0;
        run_req(0, 1, hl, rl);
        check("tmo_lat",   32'(rl), 32'd12);
        check("tmo_err",   32'(bus.Rmon_err), 32'd1);
        check("tmo_data",  bus.Rmon_data, 32'd0);
        check("tmo_polls", 32'(count_entry({1'b1, 8'h3C, 16'h0})), 32'd4);
        check("tmo_nstb",  32'(log_q.size()), 32'd7);
        check("tmo_clr",   32'(log_q[6]), 32'({1'b0, 8'h3A, 16'h0000}));
        @(posedge clk); #1;
        check("tmo_errpulse", 32'(bus.Rmon_err), 32'd0);

        // Simultaneous host write and RMON request: host first
        log_q.delete();
        bus.Host_we = 1; bus.Host_addr = 8'h10; bus.Host_wdata = 16'hABCD;
        bus.Rmon_addr = 6'h2A; grant_polls = 1; rmon_val = 32'h12345678;
        run_req(1, 1, hl, rl);
        check("both_hlat",  32'(hl), 32'd2);
        check("both_rlat",  32'(rl), 32'd13);
        check("both_first", 32'(log_q[0]), 32'({1'b0, 8'h10, 16'hABCD}));
        check("both_sel",   32'(log_q[1]), 32'({1'b0, 8'h38, 16'h002A}));
        check("both_rdata", bus.Rmon_data, 32'h12345678);

        // Reset during RPOLL
        grant_polls = 0;
        seen_poll = 0;
        @(posedge clk); #1;
        bus.Rmon_req = 1;
        for (int n = 0; n < 20 && !seen_poll; n++) begin
            @(posedge clk); #1;
            if (!bus.CSB && bus.CA == 8'h3C) seen_poll = 1;
        end
        check("rst_mid_reached", 32'(seen_poll), 32'd1);
        check("rst_mid_applyon", 32'(apply), 32'd1);
        acks_before = rmon_acks;
        Reset = 1; bus.Rmon_req = 0;
        @(posedge clk); #1;
        Reset = 0;
        check("rst_mid_csb",   32'(bus.CSB), 32'd1);
        check("rst_mid_ca",    32'(bus.CA), 32'd0);
        check("rst_mid_cdwr",  32'(bus.CD_wr), 32'd0);
        check("rst_mid_rdata", bus.Rmon_data, 32'd0);
        check("rst_mid_apply", 32'(apply), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_noack", 32'(rmon_acks), 32'(acks_before));
        check("rst_mid_idle",  32'(bus.CSB), 32'd1);

        // Fresh RMON read after reset
        bus.Rmon_addr = 6'h01; grant_polls = 1; rmon_val = 32'hCAFEF00D;
        run_req(0, 1, hl, rl);
        check("post_lat",  32'(rl), 32'd10);
        check("post_data", bus.Rmon_data, 32'hCAFEF00D);
        check("post_err",  32'(bus.Rmon_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
